// File: rtl/lcd_char_driver.sv
// HD44780 character LCD driver, 8-bit bus, write-only.
// Runs power-up wait and init once, then refreshes 32 characters in a loop.
module lcd_char_driver #(
  parameter int unsigned PWR_WAIT = 1000000,
  parameter int unsigned SETUP    = 2,
  parameter int unsigned E_HIGH   = 25,
  parameter int unsigned CMD_WAIT = 2500,
  parameter int unsigned CLR_WAIT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam int unsigned CW = 20;
  localparam int unsigned IW = 5;

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_ADDR, S_FETCH, S_WRITE, S_NEXT
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP, PH_EHIGH, PH_WAIT
  } phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      step_q, step_d;
  logic [IW-1:0]   index_d;
  logic            lcd_e_d, lcd_rs_d, init_done_d, frame_done_d;
  logic [7:0]      lcd_data_d;

  logic            tx_active, tx_done, load;
  logic            load_rs;
  logic [7:0]      load_data;
  logic [CW-1:0]   wait_m1;

  assign lcd_rw = 1'b0;

  // Clear-display needs the long busy time; every other write uses the short one.
  assign wait_m1 = (!lcd_rs && lcd_data == 8'h01) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
  assign tx_active = (state_q == S_INIT) || (state_q == S_ADDR) || (state_q == S_WRITE);

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PWR;
      phase_q    <= PH_SETUP;
      cnt_q      <= '0;
      step_q     <= '0;
      index      <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      index      <= index_d;
      lcd_e      <= lcd_e_d;
      lcd_rs     <= lcd_rs_d;
      lcd_data   <= lcd_data_d;
      init_done  <= init_done_d;
      frame_done <= frame_done_d;
    end
  end

  // Next-state: transaction sequencer plus top-level flow
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    index_d      = index;
    lcd_e_d      = lcd_e;
    lcd_rs_d     = lcd_rs;
    lcd_data_d   = lcd_data;
    init_done_d  = init_done;
    frame_done_d = 1'b0;
    tx_done      = 1'b0;
    load         = 1'b0;
    load_rs      = 1'b0;
    load_data    = 8'h00;

    if (tx_active) begin
      case (phase_q)
        PH_SETUP: begin
          if (cnt_q == CW'(SETUP - 1)) begin
            lcd_e_d = 1'b1;
            phase_d = PH_EHIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PH_EHIGH: begin
          if (cnt_q == CW'(E_HIGH - 1)) begin
            lcd_e_d = 1'b0;
            phase_d = PH_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PH_WAIT: begin
          if (cnt_q == wait_m1) begin
            tx_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: phase_d = PH_SETUP;
      endcase
    end

    case (state_q)
      S_PWR: begin
        if (cnt_q == CW'(PWR_WAIT - 1)) begin
          state_d   = S_INIT;
          step_d    = 2'd0;
          load      = 1'b1;
          load_data = 8'h38;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INIT: begin
        if (tx_done) begin
          load = 1'b1;
          case (step_q)
            2'd0:    load_data = 8'h0C;
            2'd1:    load_data = 8'h06;
            2'd2:    load_data = 8'h01;
            default: begin
              load_data   = 8'h80;
              init_done_d = 1'b1;
              index_d     = '0;
              state_d     = S_ADDR;
            end
          endcase
          step_d = step_q + 2'd1;
        end
      end
      S_ADDR: begin
        if (tx_done) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        // Upstream lookup lands one clk after index moves; sample on the second clk.
        if (cnt_q == CW'(1)) begin
          state_d   = S_WRITE;
          load      = 1'b1;
          load_rs   = 1'b1;
          load_data = char_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        if (tx_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (index == IW'(15)) begin
          index_d   = IW'(16);
          state_d   = S_ADDR;
          load      = 1'b1;
          load_data = 8'hC0;
        end else if (index == IW'(31)) begin
          index_d      = '0;
          frame_done_d = 1'b1;
          state_d      = S_ADDR;
          load         = 1'b1;
          load_data    = 8'h80;
        end else begin
          index_d = index + IW'(1);
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      default: state_d = S_PWR;
    endcase

    if (load) begin
      lcd_rs_d   = load_rs;
      lcd_data_d = load_data;
      lcd_e_d    = 1'b0;
      phase_d    = PH_SETUP;
      cnt_d      = '0;
    end
  end

endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver with shortened timing parameters.
// Cycle numbers count rising edges since reset release, sampled on the falling edge.
module tb_lcd_char_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in;
  logic [4:0] index;
  logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;
  int cyc;
  int fd_count = 0;
  int fd_cyc = -1;
  bit toggle = 1'b0;

  lcd_char_driver #(
    .PWR_WAIT(10), .SETUP(2), .E_HIGH(3), .CMD_WAIT(5), .CLR_WAIT(20)
  ) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .index(index),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Upstream ROM: registered lookup of 0x41+index; scrambles while E is high when toggling
  always @(posedge clk)
    char_in <= (toggle && lcd_e) ? 8'($urandom) : 8'h41 + 8'(index);

  always @(negedge clk)
    if (frame_done) begin
      fd_count <= fd_count + 1;
      fd_cyc   <= cyc;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next E pulse and checks its contents, timing and width.
  task automatic tx(input string tag, input logic exp_rs, input logic [7:0] exp_data,
                    input int exp_rise, input int exp_idx);
    int   n;
    int   h;
    bit   stable;
    logic r0;
    logic [7:0] d0;
    n = 0;
    while (lcd_e !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (lcd_e !== 1'b1) begin
      chk({tag, "_timeout"}, 32'(lcd_e), 32'd1);
      return;
    end
    chk({tag, "_rs"}, 32'(lcd_rs), 32'(exp_rs));
    chk({tag, "_data"}, 32'(lcd_data), 32'(exp_data));
    if (exp_rise >= 0) chk({tag, "_rise_cyc"}, 32'(cyc), 32'(exp_rise));
    if (exp_idx >= 0)  chk({tag, "_index"}, 32'(index), 32'(exp_idx));
    r0 = lcd_rs;
    d0 = lcd_data;
    h = 0;
    stable = 1'b1;
    while (lcd_e === 1'b1 && h < 50) begin
      if (lcd_rs !== r0 || lcd_data !== d0) stable = 1'b0;
      h++;
      @(negedge clk);
    end
    chk({tag, "_e_width"}, 32'(h), 32'd3);
    chk({tag, "_bus_stable"}, 32'(stable), 32'd1);
  endtask

  initial begin
    int fd0;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_e", 32'(lcd_e), 32'd0);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_rw", 32'(lcd_rw), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'h00);
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Init: 10 power-wait clks, then 10 clks per command; clear has a 20-clk wait
    tx("init_38", 1'b0, 8'h38, 12, -1);
    tx("init_0c", 1'b0, 8'h0C, 22, -1);
    tx("init_06", 1'b0, 8'h06, 32, -1);
    tx("init_01", 1'b0, 8'h01, 42, -1);
    chk("init_done_before", 32'(init_done), 32'd0);

    fd0 = fd_count;
    tx("addr_80", 1'b0, 8'h80, 67, 0);
    chk("init_done_after", 32'(init_done), 32'd1);

    for (int k = 0; k < 16; k++)
      tx($sformatf("char%0d", k), 1'b1, 8'h41 + 8'(k), 79 + 13 * k, k);
    tx("addr_c0", 1'b0, 8'hC0, 285, 16);
    for (int k = 16; k < 32; k++)
      tx($sformatf("char%0d", k), 1'b1, 8'h41 + 8'(k), 297 + 13 * (k - 16), k);

    tx("frame2_addr_80", 1'b0, 8'h80, 503, 0);
    chk("frame_done_pulses", 32'(fd_count - fd0), 32'd1);
    chk("frame_done_cyc", 32'(fd_cyc), 32'd501);
    chk("frame_done_low", 32'(frame_done), 32'd0);
    chk("init_done_held", 32'(init_done), 32'd1);

    // Second frame with char_in scrambled while E is high
    toggle = 1'b1;
    for (int k = 0; k < 5; k++)
      tx($sformatf("tog_char%0d", k), 1'b1, 8'h41 + 8'(k), 515 + 13 * k, k);

    n = 0;
    while (lcd_e !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("char5_e_high", 32'(lcd_e), 32'd1);
    chk("char5_rise_cyc", 32'(cyc), 32'd580);
    chk("char5_data", 32'(lcd_data), 32'h46);

    // Asynchronous reset while E is high
    rst = 1'b1;
    #1;
    chk("midrst_e", 32'(lcd_e), 32'd0);
    chk("midrst_rs", 32'(lcd_rs), 32'd0);
    chk("midrst_data", 32'(lcd_data), 32'h00);
    chk("midrst_index", 32'(index), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    toggle = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_hold_e", 32'(lcd_e), 32'd0);
    rst = 1'b0;

    tx("reinit_38", 1'b0, 8'h38, 12, -1);
    tx("reinit_0c", 1'b0, 8'h0C, 22, -1);
    chk("reinit_init_done", 32'(init_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_char_driver.md
LCD_CHAR_DRIVER -- requirements
Module: lcd_char_driver

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
  PWR_WAIT  1000000  clk cycles idle after reset before first command (20 ms at 50 MHz)
  SETUP     2        clk cycles RS/data stable with E low before E rises
  E_HIGH    25       clk cycles E held high
  CMD_WAIT  2500     clk cycles E low after a normal command/data write (50 us)
  CLR_WAIT  100000   clk cycles E low after clear-display command (2 ms)
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
  clk         input   1  system clock, all logic on rising edge
  rst         input   1  reset, asynchronous, active-high
  char_in     input   8  ASCII code for current index; registered upstream, valid 1 clk after index changes
  index       output  5  character position: 0-15 line 1, 16-31 line 2
  lcd_e       output  1  HD44780 enable strobe
  lcd_rs      output  1  0 = command, 1 = data
  lcd_rw      output  1  read/write select, constant 0
  lcd_data    output  8  HD44780 data bus, 8-bit mode
  init_done   output  1  high once init sequence completes; held until reset
  frame_done  output  1  one-clk pulse after char 31 is written
REQ-003 All parameters SHALL be >= 1; timing counters SHALL be 20 bits wide and saturate-free for all defaults.

Function
REQ-004 Every LCD write SHALL be one transaction: load lcd_rs/lcd_data; SETUP clks E=0; E_HIGH clks E=1; then WAIT clks E=0 (WAIT = CLR_WAIT for 0x01, else CMD_WAIT).
REQ-005 lcd_rs/lcd_data SHALL remain constant from transaction start until the next transaction loads.
REQ-006 FSM states SHALL be: PWR, INIT, ADDR, FETCH, WRITE, NEXT.
REQ-007 PWR: hold all outputs at reset values for PWR_WAIT clks, then go to INIT.
REQ-008 INIT: issue commands 0x38, 0x0C, 0x06, 0x01 in order, one transaction each; after 0x01 completes, set init_done=1 and index=0, go to ADDR.
REQ-009 ADDR: issue command 0x80 when index=0, 0xC0 when index=16; then go to FETCH.
REQ-010 FETCH: wait exactly 2 clks with index stable, then capture char_in; go to WRITE.
REQ-011 WRITE: issue data transaction (rs=1, data=captured char); then go to NEXT.
REQ-012 NEXT: if index=15, index<=16, go ADDR; if index=31, index<=0, pulse frame_done for 1 clk, go ADDR; else index<=index+1, go FETCH.
REQ-013 index SHALL change only in NEXT or on INIT exit; wrap 31->0 SHALL be the only decreasing transition.
REQ-014 After init, frames SHALL repeat continuously: 0x80, chars 0-15, 0xC0, chars 16-31, frame_done.
REQ-015 init sequence SHALL run once per reset; frames never re-issue INIT commands.
REQ-016 char_in SHALL be sampled only at end of FETCH; changes at other times have no effect on the bus.
REQ-017 lcd_e SHALL never be high for more or fewer than E_HIGH consecutive clks.

Reset
REQ-018 While rst=1: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, index=0, init_done=0, frame_done=0, FSM=PWR, counters=0.
REQ-019 rst asserted mid-transaction (including E high) SHALL force lcd_e=0 immediately (asynchronous) and restart from PWR after release.
REQ-020 After rst deassertion, the first E rising edge SHALL occur at exactly PWR_WAIT+SETUP clks.

Verification (bench params PWR_WAIT=10, SETUP=2, E_HIGH=3, CMD_WAIT=5, CLR_WAIT=20)
REQ-021 Reset release -> E rises at clk 12 with rs=0, data=0x38; E high 3 clks; init commands 0x38, 0x0C, 0x06, 0x01 in order.
REQ-022 After 0x01 -> E stays low 20 clks; init_done rises; next transaction is rs=0, data=0x80.
REQ-023 Upstream model returns 0x41+index one clk after index changes -> data writes 0x41..0x50, then cmd 0xC0, then 0x51..0x60.
REQ-024 Completion of char 31 -> frame_done high exactly 1 clk; index=0; next transaction cmd 0x80, no INIT commands.
REQ-025 rst pulsed while lcd_e=1 during char 5 -> lcd_e=0 same clk; outputs at reset values; init sequence restarts from PWR.
REQ-026 char_in toggled every clk outside FETCH -> bus data always equals value present at FETCH end.
